// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing both ports of a true dual-port block RAM among NUM_REQ requesters.
// After reset it can zero-fill the RAM, and it returns synchronous read data to whichever requester issued the read.
module bram_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DWIDTH         = 8,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DWIDTH-1:0] rsp_data,
    output logic                      init_done,
    output logic                      bram_clk_en,
    output logic                      bram_singleportmode,
    output logic                      bram_port_en_0,
    output logic                      bram_wr_en_0,
    output logic [ADDR_W-1:0]         bram_addr_0,
    output logic [DWIDTH-1:0]         bram_data_in_0,
    input  logic [DWIDTH-1:0]         bram_data_out_0,
    output logic                      bram_port_en_1,
    output logic                      bram_wr_en_1,
    output logic [ADDR_W-1:0]         bram_addr_1,
    output logic [DWIDTH-1:0]         bram_data_in_1,
    input  logic [DWIDTH-1:0]         bram_data_out_1
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {INIT, RUN} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   init_addr_reg, init_addr_next;
    logic                init_done_reg, init_done_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DWIDTH-1:0]   wdata_arr [NUM_REQ];
    logic [PTR_W:0]      scan_sum  [NUM_REQ];
    logic [PTR_W-1:0]    scan_idx  [NUM_REQ];

    logic                grant_a, grant_b;
    logic [PTR_W-1:0]    idx_a, idx_b;

    logic                rsp_valid_reg [NUM_REQ];
    logic                rsp_port_reg  [NUM_REQ];
    logic [DWIDTH-1:0]   hold_reg      [NUM_REQ];
    logic [DWIDTH-1:0]   rsp_data_cur  [NUM_REQ];

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // scan_idx[k] is the k-th requester visited when starting from rr_ptr.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DWIDTH +: DWIDTH];
        assign scan_sum[gi]  = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
        assign scan_idx[gi]  = (scan_sum[gi] >= (PTR_W+1)'(NUM_REQ))
                             ? PTR_W'(scan_sum[gi] - (PTR_W+1)'(NUM_REQ))
                             : PTR_W'(scan_sum[gi]);
        assign rsp_data_cur[gi] = rsp_valid_reg[gi]
                                ? (rsp_port_reg[gi] ? bram_data_out_1 : bram_data_out_0)
                                : hold_reg[gi];
        assign rsp_data[gi*DWIDTH +: DWIDTH] = rsp_data_cur[gi];
        assign rsp_valid[gi] = rsp_valid_reg[gi];
    end

    // A second grant may not touch the first grant's address if either of them writes.
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        idx_a     = '0;
        idx_b     = '0;
        req_ready = '0;
        if (state_reg == RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[scan_idx[k]]) begin
                    if (!grant_a) begin
                        grant_a = 1'b1;
                        idx_a   = scan_idx[k];
                    end else if (!grant_b &&
                                 !((addr_arr[scan_idx[k]] == addr_arr[idx_a]) &&
                                   (req_we[idx_a] || req_we[scan_idx[k]]))) begin
                        grant_b = 1'b1;
                        idx_b   = scan_idx[k];
                    end
                end
            end
        end
        if (grant_a) req_ready[idx_a] = 1'b1;
        if (grant_b) req_ready[idx_b] = 1'b1;
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_b)      rr_ptr_next = ptr_after(idx_b);
        else if (grant_a) rr_ptr_next = ptr_after(idx_a);
    end

    always_comb begin
        state_next     = state_reg;
        init_addr_next = init_addr_reg;
        init_done_next = init_done_reg;
        case (state_reg)
            INIT: begin
                init_addr_next = init_addr_reg + ADDR_W'(2);
                if (init_addr_reg == ADDR_W'(DEPTH - 2)) begin
                    state_next     = RUN;
                    init_done_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bram_port_en_0 = 1'b0;
        bram_wr_en_0   = 1'b0;
        bram_addr_0    = '0;
        bram_data_in_0 = '0;
        bram_port_en_1 = 1'b0;
        bram_wr_en_1   = 1'b0;
        bram_addr_1    = '0;
        bram_data_in_1 = '0;
        if (state_reg == INIT) begin
            bram_port_en_0 = 1'b1;
            bram_wr_en_0   = 1'b1;
            bram_addr_0    = init_addr_reg;
            bram_port_en_1 = 1'b1;
            bram_wr_en_1   = 1'b1;
            bram_addr_1    = init_addr_reg + ADDR_W'(1);
        end else begin
            if (grant_a) begin
                bram_port_en_0 = 1'b1;
                bram_wr_en_0   = req_we[idx_a];
                bram_addr_0    = addr_arr[idx_a];
                bram_data_in_0 = wdata_arr[idx_a];
            end
            if (grant_b) begin
                bram_port_en_1 = 1'b1;
                bram_wr_en_1   = req_we[idx_b];
                bram_addr_1    = addr_arr[idx_b];
                bram_data_in_1 = wdata_arr[idx_b];
            end
        end
    end

    assign init_done           = init_done_reg;
    assign bram_clk_en         = 1'b1;
    assign bram_singleportmode = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RESET_STATE;
            init_addr_reg <= '0;
            init_done_reg <= (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;
            rr_ptr_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            init_addr_reg <= init_addr_next;
            init_done_reg <= init_done_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    // Remember which port each requester's read went to, so the RAM output is steered back next cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                rsp_valid_reg[i] <= 1'b0;
                rsp_port_reg[i]  <= 1'b0;
                hold_reg[i]      <= '0;
            end else begin
                rsp_valid_reg[i] <= !req_we[i] &&
                                    ((grant_a && (idx_a == PTR_W'(i))) ||
                                     (grant_b && (idx_b == PTR_W'(i))));
                rsp_port_reg[i]  <= grant_b && (idx_b == PTR_W'(i));
                hold_reg[i]      <= rsp_data_cur[i];
            end
        end
    end
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a behavioural dual-port RAM and a per-requester
// read-response scoreboard checked by an independent monitor.
module tb_bram_rr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AW = 4;

    logic clk, rst;
    logic [NR-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata, rsp_data;
    logic init_done, bram_clk_en, bram_singleportmode;
    logic bram_port_en_0, bram_wr_en_0, bram_port_en_1, bram_wr_en_1;
    logic [AW-1:0] bram_addr_0, bram_addr_1;
    logic [DW-1:0] bram_data_in_0, bram_data_in_1, bram_data_out_0, bram_data_out_1;

    logic [DW-1:0] mem [DP];
    logic collision_flag;
    logic fill;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [DW-1:0] exp_q [NR][$];

    bram_rr_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .DEPTH(DP), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .init_done(init_done), .bram_clk_en(bram_clk_en), .bram_singleportmode(bram_singleportmode),
        .bram_port_en_0(bram_port_en_0), .bram_wr_en_0(bram_wr_en_0), .bram_addr_0(bram_addr_0),
        .bram_data_in_0(bram_data_in_0), .bram_data_out_0(bram_data_out_0),
        .bram_port_en_1(bram_port_en_1), .bram_wr_en_1(bram_wr_en_1), .bram_addr_1(bram_addr_1),
        .bram_data_in_1(bram_data_in_1), .bram_data_out_1(bram_data_out_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAM; starts full of 0xEE so only a real zero-fill reads back 0.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DP; i++) mem[i] <= 8'hEE;
            collision_flag <= 1'b0;
        end else begin
            if (bram_port_en_0) begin
                if (bram_wr_en_0) mem[bram_addr_0] <= bram_data_in_0;
                else              bram_data_out_0  <= mem[bram_addr_0];
            end
            if (bram_port_en_1) begin
                if (bram_wr_en_1) mem[bram_addr_1] <= bram_data_in_1;
                else              bram_data_out_1  <= mem[bram_addr_1];
            end
            if (bram_port_en_0 && bram_port_en_1 && bram_addr_0 == bram_addr_1 &&
                (bram_wr_en_0 || bram_wr_en_1))
                collision_flag <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got=%0h want=%0h", name, got, want);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
        req_we[i]    = 1'b0;
    endtask

    task automatic chk_ready(input string name, input logic [NR-1:0] want);
        chk(name, {28'b0, req_ready}, {28'b0, want});
        $display("t=%0t %s ready=%b", $time, name, req_ready);
    endtask

    // Monitor: every presented response must match the oldest expectation for that requester.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rsp_valid[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    total_cnt++;
                    $display("FAIL rsp_unexpected req%0d: got=%0h want=none", i, rsp_data[i*DW +: DW]);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q[i].pop_front();
                    chk($sformatf("rsp_req%0d", i), {24'b0, rsp_data[i*DW +: DW]}, {24'b0, e});
                    $display("t=%0t rsp req%0d data=%0h", $time, i, rsp_data[i*DW +: DW]);
                end
            end
        end
    end

    initial begin
        int cnt [NR];
        logic [NR-1:0] want;
        rst = 1'b1;
        fill = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        tick;
        fill = 1'b0;
        @(negedge clk);
        chk("reset_init_done", {31'b0, init_done}, 32'd0);
        chk("reset_rsp_valid", {28'b0, rsp_valid}, 32'd0);
        chk_ready("reset_ready", 4'b0000);
        tick;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), 8'h00);

        // INIT: 8 cycles of zero-fill with all requesters waiting.
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("init_done_low_c%0d", c), {31'b0, init_done}, 32'd0);
            chk($sformatf("init_ready_c%0d", c), {28'b0, req_ready}, 32'd0);
            tick;
        end

        // All four read continuously: pairs alternate {0,1},{2,3}, all data zero.
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) chk("init_done_high", {31'b0, init_done}, 32'd1);
            want = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            chk_ready($sformatf("rr_read_c%0d", c), want);
            for (int i = 0; i < NR; i++) if (want[i]) exp_q[i].push_back(8'h00);
            tick;
            for (int i = 0; i < NR; i++) begin
                if (want[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 4) clr_req(i);
                    else req_addr[i*AW +: AW] = AW'(i + 4 * cnt[i]);
                end
            end
        end

        // r0 writes A5@3, r2 writes 5A@7 together.
        set_req(0, 1'b1, 4'd3, 8'hA5);
        set_req(2, 1'b1, 4'd7, 8'h5A);
        @(negedge clk);
        chk("rsp_latency_rr", {28'b0, rsp_valid}, 32'b1100);
        chk_ready("dual_write", 4'b0101);
        tick;
        clr_req(0); clr_req(2);

        set_req(0, 1'b0, 4'd3, 8'h00);
        set_req(2, 1'b0, 4'd7, 8'h00);
        @(negedge clk);
        chk_ready("dual_read", 4'b0101);
        exp_q[0].push_back(8'hA5);
        exp_q[2].push_back(8'h5A);
        tick;
        clr_req(0); clr_req(2);
        @(negedge clk);
        chk("rsp_latency_dual", {28'b0, rsp_valid}, 32'b0101);
        tick;
        @(negedge clk);
        chk("rsp_hold_r0", {20'b0, rsp_valid, rsp_data[7:0]}, {20'b0, 4'b0000, 8'hA5});

        // Bring rr_ptr to 0 with a lone read from r3.
        tick;
        set_req(3, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        chk_ready("lone_r3", 4'b1000);
        exp_q[3].push_back(8'h00);
        tick;
        clr_req(3);

        // r1 writes 11@5 while r2 reads @5: r2 deferred one cycle.
        set_req(1, 1'b1, 4'd5, 8'h11);
        set_req(2, 1'b0, 4'd5, 8'h00);
        @(negedge clk);
        chk_ready("raw_conflict", 4'b0010);
        tick;
        clr_req(1);
        @(negedge clk);
        chk_ready("raw_deferred", 4'b0100);
        exp_q[2].push_back(8'h11);
        tick;
        clr_req(2);
        @(negedge clk);
        chk("rsp_latency_raw", {28'b0, rsp_valid}, 32'b0100);

        // rr_ptr=3: r3 and r0 both write @9; r3 first, r0 next cycle.
        tick;
        set_req(3, 1'b1, 4'd9, 8'h33);
        set_req(0, 1'b1, 4'd9, 8'h77);
        @(negedge clk);
        chk_ready("waw_first", 4'b1000);
        tick;
        clr_req(3);
        @(negedge clk);
        chk_ready("waw_second", 4'b0001);
        tick;
        clr_req(0);
        set_req(1, 1'b0, 4'd9, 8'h00);
        @(negedge clk);
        chk_ready("waw_readback", 4'b0010);
        exp_q[1].push_back(8'h77);
        tick;
        clr_req(1);

        // Read grant, then reset in the following cycle.
        set_req(1, 1'b0, 4'd3, 8'h00);
        @(negedge clk);
        chk_ready("pre_reset_read", 4'b0010);
        exp_q[1].push_back(8'hA5);
        tick;
        clr_req(1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_req(3, 1'b0, 4'd5, 8'h00);
        set_req(0, 1'b0, 4'd3, 8'h00);
        set_req(1, 1'b0, 4'd7, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk("post_reset_rsp_valid", {28'b0, rsp_valid}, 32'd0);
            chk($sformatf("reinit_done_low_c%0d", c), {31'b0, init_done}, 32'd0);
            chk($sformatf("reinit_ready_c%0d", c), {28'b0, req_ready}, 32'd0);
            tick;
        end
        @(negedge clk);
        chk("reinit_done_high", {31'b0, init_done}, 32'd1);
        chk_ready("post_reset_ptr0", 4'b0011);
        exp_q[0].push_back(8'h00);
        exp_q[1].push_back(8'h00);
        tick;
        clr_req(0); clr_req(1);
        @(negedge clk);
        chk_ready("post_reset_r3", 4'b1000);
        exp_q[3].push_back(8'h00);
        tick;
        clr_req(3);
        tick;
        tick;
        @(negedge clk);
        chk("collision_flag", {31'b0, collision_flag}, 32'd0);
        chk("scoreboard_empty",
            exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Shares the two ports of the true dual-port block RAM among NUM_REQ requesters.
- Each cycle it grants up to two requests in round-robin order: the first goes to port 0, the second to port 1.
- It holds back any second grant that would touch the same address as the first.
- After reset it optionally zero-fills the RAM, then routes synchronous read data back to the requester that issued the read.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DWIDTH, 8, data width; matches the RAM.
- DEPTH, 256, RAM words; must be even.
- ADDR_W, $clog2(DEPTH), address width.
- CLEAR_ON_RESET, 1, 1 = run the INIT zero-fill after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DWIDTH  packed write data.
- req_ready  out  NUM_REQ  grant; combinational from the request inputs, state and rr_ptr.
- rsp_valid  out  NUM_REQ  read data valid, registered.
- rsp_data  out  NUM_REQ*DWIDTH  packed read data.
- init_done  out  1  high once the RAM is usable.
- bram_clk_en  out  1  tied to 1.
- bram_singleportmode  out  1  tied to 0.
- bram_port_en_0, bram_wr_en_0  out  1  port 0 enable and write enable.
- bram_addr_0  out  ADDR_W  port 0 address.
- bram_data_in_0  out  DWIDTH  port 0 write data.
- bram_data_out_0  in  DWIDTH  port 0 read data; RAM is built with READ_SYNC=1.
- bram_port_en_1, bram_wr_en_1, bram_addr_1, bram_data_in_1, bram_data_out_1: same as port 0, for port 1.

Behaviour:
- States: INIT and RUN.
- Reset values:
  - state = INIT if CLEAR_ON_RESET, else RUN.
  - init_addr = 0, rr_ptr = 0, rsp_valid = 0, rsp_data = 0.
  - init_done = 0 if CLEAR_ON_RESET, else 1.
  - Reset mid-operation drops any in-flight read response: rsp_valid is 0 in the cycle after rst.
- INIT:
  - req_ready = 0.
  - Port 0 writes 0 to init_addr; port 1 writes 0 to init_addr+1.
  - init_addr increments by 2 each cycle.
  - After the cycle that writes DEPTH-2/DEPTH-1, move to RUN and set init_done = 1. INIT lasts DEPTH/2 cycles.
- RUN arbitration (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - First valid requester A gets port 0.
  - The next valid requester B gets port 1, unless addr_B == addr_A and (we_A or we_B). In that case B is not granted and the scan continues to the next eligible requester C under the same rule.
  - At most two grants per cycle.
  - A request transfers when req_valid & req_ready.
  - A requester must hold valid, we, addr and wdata stable until it is granted.
- Port drive:
  - A granted port has port_en = 1, wr_en = we, and the requester's addr and wdata.
  - An ungranted port has port_en = 0, wr_en = 0, and addr/data = 0.
- Round-robin pointer:
  - When at least one grant occurs, rr_ptr <= (index of the last granted requester + 1) mod NUM_REQ.
  - With no grants, rr_ptr holds.
- Read responses:
  - A read granted in cycle t produces rsp_valid[i] = 1 in cycle t+1, with rsp_data[i] = bram_data_out of the port used.
  - Keep a registered port select and requester id per port.
  - Writes produce no response.
  - rsp_data of a non-responding requester holds its last value.
- Same-cycle writes on both ports go to different addresses by construction; the bench must never see the RAM collision_flag asserted.
- A requester granted in cycle t may be granted again in cycle t+1 if the scan reaches it again. Back-to-back reads from the same requester give back-to-back rsp_valid pulses.
- Throughput: 2 accesses per cycle when at least two requesters are valid and they do not conflict.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: after rst, init_done is 0 for 8 cycles and goes high in cycle 9. Reads of addresses 0..15 all return 0x00.
- Requesters 0 and 2 write 0xA5@3 and 0x5A@7 in the same cycle: both are granted that cycle (r0 on port 0, r2 on port 1). Later reads of 3 and 7 return 0xA5 and 0x5A one cycle after grant, on rsp_valid[0] and rsp_valid[2] respectively.
- Requester 1 writes 0x11@5 while requester 2 reads @5, rr_ptr=0: only r1 is granted in cycle t. r2 is granted in t+1 and gets rsp_data = 0x11 in t+2.
- All 4 requesters read continuously, rr_ptr=0: grant pairs are {0,1}, {2,3}, {0,1}, ... with one rsp_valid per requester every 2 cycles. No requester goes more than 2 cycles without a grant.
- rst asserted the cycle after a read grant: no rsp_valid the next cycle, rr_ptr=0, INIT restarts and init_done drops to 0.
- Two writes to the same address from requesters 0 and 3: only the one nearer rr_ptr is granted that cycle, and the other is granted in the next cycle. collision_flag stays 0 throughout.
